spi_sensor_master: RTL
======================

Name: spi_sensor_master

Overview:
- SPI initiator that configures and reads out the digital VT sensor macro from the test-chip digital wrapper or an on-board FPGA.
- Drives the sensor's SPI_CS, SPI_CLK and SPI_MOSI pins, and captures SPI_MISO.
- Each transaction is one 64-bit full-duplex frame: the config word shifts out while the previous result word (TDC + RO count) shifts in.
- Optionally emits trailing SPI_CLK pulses with CS deasserted, to clock the sensor's measurement-window counter.

Parameters:
- CLK_DIV, 4, system clocks per SPI_CLK half-period; legal range 1..255.
- FRAME_BITS, 64, bits per frame; must match the sensor shift register.
- CS_SETUP, 2, system clocks from SPI_CS falling to the first SPI_CLK rising edge.
- CS_HOLD, 2, system clocks from the last SPI_CLK falling edge to SPI_CS rising.
- CS_GAP, 4, minimum system clocks SPI_CS stays high between frames.
- MEAS_CLKS, 255, trailing SPI_CLK pulses; used only with SPI_MEAS_CLK_EN.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- i_Start  in  1  request a frame; sampled only in IDLE.
- i_TxWord  in  64  config word, latched on the accepted i_Start.
- o_RxWord  out  64  last received word; valid when o_Done pulses and held until the next o_Done.
- o_Busy  out  1  high from the cycle after start acceptance through the o_Done cycle.
- o_Done  out  1  single-cycle completion pulse.
- SPI_CS  out  1  chip select, active-low.
- SPI_CLK  out  1  serial clock, idle low.
- SPI_MOSI  out  1  serial data to the sensor.
- SPI_MISO  in  1  serial data from the sensor.

Behaviour:
- Protocol: mode 0 (CPOL=0, CPHA=0), MSB first. MOSI changes after a SPI_CLK falling edge; MISO is sampled on the rising edge.
- Reset values: SPI_CS=1, SPI_CLK=0, SPI_MOSI=0, o_Busy=0, o_Done=0, o_RxWord=0, FSM=IDLE, all counters 0.
- Asserting RST mid-frame aborts the frame immediately. No o_Done is issued and o_RxWord keeps 0.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP, MEAS (feature only), DONE.
- IDLE:
  - i_Start=1 latches i_TxWord into the tx shift register.
  - SPI_MOSI=i_TxWord[63], SPI_CS=0, then go to SETUP.
- SETUP: wait CS_SETUP clocks, then go to SHIFT with divider=0 and bit counter=FRAME_BITS.
- SHIFT:
  - The divider counts 0..CLK_DIV-1. At terminal count SPI_CLK toggles.
  - Rising toggle: rx shift register <= {rx[62:0], SPI_MISO}.
  - Falling toggle: tx shifts left, SPI_MOSI <= next MSB, bit counter decrements.
  - When the counter reaches 0 on a falling toggle, go to HOLD. SPI_MOSI then returns to 0.
  - SPI_CLK period = 2*CLK_DIV clocks. A frame has exactly 64 rising edges.
- HOLD: CS_HOLD clocks, then SPI_CS=1 and go to GAP (or MEAS with the feature).
- GAP: CS_GAP clocks with CS high, then DONE.
- DONE (one cycle): o_RxWord <= rx shift register, o_Done=1, then IDLE. A new start is accepted the cycle after DONE.
- Start handling: i_Start while not IDLE is ignored, with no queuing. i_Start held high starts back-to-back frames separated by at least CS_GAP+1 clocks of CS high.
- i_TxWord changes after acceptance have no effect on the frame in progress.

Optional Feature:
- Macro SPI_MEAS_CLK_EN.
- Defined:
  - After HOLD, enter MEAS with SPI_CS=1.
  - Emit MEAS_CLKS full SPI_CLK pulses at the same divider rate, then go to GAP.
  - MEAS_CLKS=0 skips MEAS.
  - This drives the sensor's SPI-clock counter so the RO enable window is exactly that many pulses.
- Undefined: the MEAS state and the MEAS_CLKS counter logic are absent. SPI_CLK never toggles while SPI_CS=1.

Decomposition:
- Shared package spi_sensor_pkg holds:
  - state enum
  - FRAME_BITS default
  - config-word field offsets: RO select [40:32], mux select [51:48], end count [63:56], dummy select [31:0]
  - result-word offsets: TDC [47:0], count [63:48]
- One sub-module, spi_clk_div: divider counter with enable, producing the half-period tick.
- The FSM and shift registers stay in the top module.

Test Plan:
- Reset mid-SHIFT (after 20 bits), CLK_DIV=4 -> SPI_CS=1, SPI_CLK=0, o_Busy=0 within the same cycle; no o_Done; o_RxWord=0.
- Start with i_TxWord=64'hFF01_0000_0000_0155, slave model returning 64'h1234_5678_9ABC_DEF0 -> MOSI captured on rising edges equals the tx word; o_RxWord=64'h1234_5678_9ABC_DEF0 at o_Done.
- Timing, CLK_DIV=4 -> exactly 64 rising SPI_CLK edges, each 8 clocks apart. First rising edge 2 clocks plus one half-period after CS falls; CS rises 2 clocks after the last falling edge.
- i_Start pulsed during SHIFT, then held continuously -> mid-frame pulse ignored; consecutive frames show at least 4 clocks of CS high between them; o_Done is one cycle wide per frame.
- With SPI_MEAS_CLK_EN, MEAS_CLKS=255 -> 255 SPI_CLK pulses with SPI_CS=1 between HOLD and GAP. Without the macro -> zero SPI_CLK toggles while CS is high.
- CLK_DIV=1 -> SPI_CLK period 2 clocks; 64-bit loopback (MISO tied to MOSI) returns o_RxWord equal to i_TxWord.

Source files
------------

// File: rtl/spi_sensor_pkg.sv
// Shared definitions for the VT sensor SPI master: FSM state encoding,
// frame size default and the bit layout of the config and result words.
// The MEAS state only exists when SPI_MEAS_CLK_EN is defined.
package spi_sensor_pkg;

  localparam int FRAME_BITS_DEF = 64;

  // Config word (shifted out on MOSI)
  localparam int CFG_DUMMY_LSB = 0;
  localparam int CFG_DUMMY_MSB = 31;
  localparam int CFG_RO_LSB    = 32;
  localparam int CFG_RO_MSB    = 40;
  localparam int CFG_MUX_LSB   = 48;
  localparam int CFG_MUX_MSB   = 51;
  localparam int CFG_END_LSB   = 56;
  localparam int CFG_END_MSB   = 63;

  // Result word (shifted in on MISO)
  localparam int RES_TDC_LSB = 0;
  localparam int RES_TDC_MSB = 47;
  localparam int RES_CNT_LSB = 48;
  localparam int RES_CNT_MSB = 63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
`ifdef SPI_MEAS_CLK_EN
    ST_MEAS,
`endif
    ST_DONE
  } state_t;

  // Assemble a config word from its fields; unused bits are zero.
  function automatic logic [63:0] cfg_word(input logic [7:0]  end_cnt,
                                           input logic [3:0]  mux_sel,
                                           input logic [8:0]  ro_sel,
                                           input logic [31:0] dummy_sel);
    logic [63:0] w;
    w = '0;
    w[CFG_END_MSB:CFG_END_LSB]     = end_cnt;
    w[CFG_MUX_MSB:CFG_MUX_LSB]     = mux_sel;
    w[CFG_RO_MSB:CFG_RO_LSB]       = ro_sel;
    w[CFG_DUMMY_MSB:CFG_DUMMY_LSB] = dummy_sel;
    return w;
  endfunction

  function automatic logic [47:0] res_tdc(input logic [63:0] w);
    return w[RES_TDC_MSB:RES_TDC_LSB];
  endfunction

  function automatic logic [15:0] res_count(input logic [63:0] w);
    return w[RES_CNT_MSB:RES_CNT_LSB];
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for SPI_CLK. Counts 0..CLK_DIV-1 while enabled
// and clears whenever disabled, so every enable starts a full half-period.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  // Divider counter: wraps at terminal count, held at zero when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_sensor_master.sv
// SPI mode-0 initiator for the VT sensor macro. One full-duplex frame per
// start: config word out on MOSI (MSB first) while the previous result word
// shifts in from MISO. Define SPI_MEAS_CLK_EN to emit MEAS_CLKS trailing
// SPI_CLK pulses with CS high after each frame (measurement window clock).
module spi_sensor_master
  import spi_sensor_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 4,
  parameter int MEAS_CLKS  = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_Start,
  input  logic [FRAME_BITS-1:0] i_TxWord,
  output logic [FRAME_BITS-1:0] o_RxWord,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  SPI_CS,
  output logic                  SPI_CLK,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO
);

  if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("CLK_DIV must be in 1..255");
  end
  if (FRAME_BITS < 2) begin : g_bad_frame_bits
    $error("FRAME_BITS must be at least 2");
  end
  if (MEAS_CLKS < 0 || MEAS_CLKS > 65535) begin : g_bad_meas_clks
    $error("MEAS_CLKS must be in 0..65535");
  end

  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam logic [BW-1:0] BITS_INIT  = BW'(FRAME_BITS);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  // A zero wait parameter still spends one cycle in its state.
  localparam logic [15:0]   SETUP_LAST = 16'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
  localparam logic [15:0]   HOLD_LAST  = 16'((CS_HOLD  > 0) ? CS_HOLD  - 1 : 0);
  localparam logic [15:0]   GAP_LAST   = 16'((CS_GAP   > 0) ? CS_GAP   - 1 : 0);

  state_t                state, state_nxt;
  logic [15:0]           wait_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;
  logic                  div_en;
  logic                  tick;

`ifdef SPI_MEAS_CLK_EN
  localparam bit          MEAS_ON   = (MEAS_CLKS > 0);
  localparam logic [15:0] MEAS_LAST = 16'((MEAS_CLKS > 0) ? MEAS_CLKS - 1 : 0);
  logic [15:0] meas_cnt;
`endif

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (CLK),
    .rst  (RST),
    .en   (div_en),
    .tick (tick)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and status outputs; a falling toggle is tick with SPI_CLK high
  always_comb begin
    state_nxt = state;
    div_en    = 1'b0;
    o_Busy    = (state != ST_IDLE);
    o_Done    = (state == ST_DONE);
    case (state)
      ST_IDLE:  if (i_Start) state_nxt = ST_SETUP;
      ST_SETUP: if (wait_cnt == SETUP_LAST) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        div_en = 1'b1;
        if (tick && SPI_CLK && bit_cnt == BIT_ONE) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
`ifdef SPI_MEAS_CLK_EN
        if (wait_cnt == HOLD_LAST) state_nxt = MEAS_ON ? ST_MEAS : ST_GAP;
`else
        if (wait_cnt == HOLD_LAST) state_nxt = ST_GAP;
`endif
      end
`ifdef SPI_MEAS_CLK_EN
      ST_MEAS: begin
        div_en = 1'b1;
        if (tick && SPI_CLK && meas_cnt == MEAS_LAST) state_nxt = ST_GAP;
      end
`endif
      ST_GAP:   if (wait_cnt == GAP_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Pin drivers, shift registers and counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SPI_CS   <= 1'b1;
      SPI_CLK  <= 1'b0;
      SPI_MOSI <= 1'b0;
      o_RxWord <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
`ifdef SPI_MEAS_CLK_EN
      meas_cnt <= '0;
`endif
    end else begin
      wait_cnt <= (state_nxt != state) ? 16'd0 : wait_cnt + 16'd1;
      case (state)
        ST_IDLE: begin
          if (i_Start) begin
            tx_sr    <= i_TxWord;
            SPI_MOSI <= i_TxWord[FRAME_BITS-1];
            SPI_CS   <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (state_nxt == ST_SHIFT) bit_cnt <= BITS_INIT;
        end
        ST_SHIFT: begin
          if (tick) begin
            SPI_CLK <= ~SPI_CLK;
            if (!SPI_CLK) begin
              rx_sr <= {rx_sr[FRAME_BITS-2:0], SPI_MISO};
            end else begin
              tx_sr    <= tx_sr << 1;
              bit_cnt  <= bit_cnt - BIT_ONE;
              SPI_MOSI <= (bit_cnt == BIT_ONE) ? 1'b0 : tx_sr[FRAME_BITS-2];
            end
          end
        end
        ST_HOLD: begin
          if (state_nxt != ST_HOLD) SPI_CS <= 1'b1;
`ifdef SPI_MEAS_CLK_EN
          meas_cnt <= '0;
`endif
        end
`ifdef SPI_MEAS_CLK_EN
        ST_MEAS: begin
          if (tick) begin
            SPI_CLK <= ~SPI_CLK;
            if (SPI_CLK) meas_cnt <= meas_cnt + 16'd1;
          end
        end
`endif
        ST_GAP: begin
          // Load on the way into DONE so the word is valid while o_Done is high
          if (state_nxt == ST_DONE) o_RxWord <= rx_sr;
        end
        default: ;
      endcase
    end
  end

endmodule
